// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// Stage counts are derived from the operand width and the number of prefix levels per stage.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int levels_f(input int width);
    return clog2(width);
  endfunction

  function automatic int tree_stages_f(input int width, input int lvl_per_stage);
    return (clog2(width) + lvl_per_stage - 1) / lvl_per_stage;
  endfunction

endpackage

// File: rtl/prefix_pg_cell.sv
// Kogge-Stone black cell: merges a high (g,p) span with the adjacent lower span.
// Where only the group generate is consumed downstream, it acts as a gray cell.
module prefix_pg_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and status flags.
// Tree position 0 carries c0, so the prefix generate at position i is the carry into bit i.
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int LVL_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS      = levels_f(WIDTH);
  localparam int TREE_STAGES = tree_stages_f(WIDTH, LVL_PER_STAGE);
  localparam int LAST        = LEVELS - 1;

  logic                 stall;
  logic [TREE_STAGES:0] vld_q, vld_d;

  pg_t  [WIDTH-1:0] tree_q [TREE_STAGES];
  logic [WIDTH-1:0] bitp_q [TREE_STAGES];
  logic             gmsb_q [TREE_STAGES];

  pg_t  [WIDTH-1:0] tree0_d;
  logic [WIDTH-1:0] bitp0_d;
  logic             gmsb0_d;

  pg_t  [WIDTH-1:0] lvl_in  [LEVELS];
  pg_t  [WIDTH-1:0] lvl_out [LEVELS];

  logic [WIDTH-1:0] sum_q, sum_d, carry, fin_p;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             unused_fin_p;

  assign stall    = vld_q[TREE_STAGES] & ~out_ready;
  assign in_ready = ~stall;
  assign vld_d    = {vld_q[TREE_STAGES-1:0], in_valid};

  always_comb begin : stage0
    logic [WIDTH-1:0] b_eff, g_bit, p_bit;
    logic             c0;
    b_eff   = sub ? ~b : b;
    c0      = sub | cin;
    g_bit   = a & b_eff;
    p_bit   = a ^ b_eff;
    tree0_d = '0;
    tree0_d[0] = '{g: c0, p: 1'b0};
    for (int i = 0; i < WIDTH - 1; i++) begin
      tree0_d[i+1] = '{g: g_bit[i], p: p_bit[i]};
    end
    bitp0_d = p_bit;
    gmsb0_d = g_bit[WIDTH-1];
  end

  // Datapath registers need no reset: the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (!stall) begin
      tree_q[0] <= tree0_d;
      bitp_q[0] <= bitp0_d;
      gmsb_q[0] <= gmsb0_d;
    end
  end

  for (genvar k = 1; k < TREE_STAGES; k++) begin : g_stage
    pg_t [WIDTH-1:0] tree_d;
    assign tree_d = lvl_out[k*LVL_PER_STAGE-1];
    always_ff @(posedge clk) begin
      if (!stall) begin
        tree_q[k] <= tree_d;
        bitp_q[k] <= bitp_q[k-1];
        gmsb_q[k] <= gmsb_q[k-1];
      end
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SPAN = 1 << l;
    if (l % LVL_PER_STAGE == 0) begin : g_cut
      assign lvl_in[l] = tree_q[l/LVL_PER_STAGE];
    end else begin : g_chain
      assign lvl_in[l] = lvl_out[l-1];
    end
    for (genvar j = 0; j < WIDTH; j++) begin : g_pos
      if (j >= SPAN) begin : g_cell
        prefix_pg_cell u_cell (
          .g_hi (lvl_in[l][j].g),
          .p_hi (lvl_in[l][j].p),
          .g_lo (lvl_in[l][j-SPAN].g),
          .p_lo (lvl_in[l][j-SPAN].p),
          .g    (lvl_out[l][j].g),
          .p    (lvl_out[l][j].p)
        );
      end else begin : g_pass
        assign lvl_out[l][j] = lvl_in[l][j];
      end
    end
  end

  always_comb begin
    carry = '0;
    fin_p = '0;
    for (int j = 0; j < WIDTH; j++) begin
      carry[j] = lvl_out[LAST][j].g;
      fin_p[j] = lvl_out[LAST][j].p;
    end
    sum_d  = bitp_q[TREE_STAGES-1] ^ carry;
    cout_d = gmsb_q[TREE_STAGES-1] | (bitp_q[TREE_STAGES-1][WIDTH-1] & carry[WIDTH-1]);
    ovf_d  = carry[WIDTH-1] ^ cout_d;
    zero_d = ~|sum_d;
  end

  // Group propagate of the last level has no consumer.
  assign unused_fin_p = ^fin_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      vld_q <= vld_d;
      if (vld_q[TREE_STAGES-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = vld_q[TREE_STAGES];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
